// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard-controller pipeline signals.
// master: pipeline side that reports status and consumes enables/flushes.
// slave:  the hazard controller itself.
interface hazard_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    // pipeline status seen by the controller
    logic             ihit;
    logic             dhit;
    logic             exmem_dren;
    logic             exmem_dwen;
    logic             idex_dren;
    logic [REG_W-1:0] idex_rt;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic             redirect;
    logic             memwb_halt;

    // latch controls and status produced by the controller
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ihit, dhit, exmem_dren, exmem_dwen, idex_dren,
               idex_rt, ifid_rs, ifid_rt, redirect, memwb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, exmem_dren, exmem_dwen, idex_dren,
               idex_rt, ifid_rs, ifid_rt, redirect, memwb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and flow controller for the 5-stage pipeline.
// Priority: halted > data-memory freeze > redirect > load-use > fetch miss.
// Controls are combinational from state and inputs; state moves on CLK.
// Optional performance counters are built only when HAZARD_PERF_EN is defined;
// otherwise stall_cnt/flush_cnt are tied to zero.
module hazard_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic          CLK,
    input  logic          RST,
    hazard_ctrl_if.slave  hz
);

    localparam logic [1:0] RUN        = 2'b00;
    localparam logic [1:0] LOAD_STALL = 2'b01;
    localparam logic [1:0] HALTED     = 2'b10;

    logic [1:0] state_q, state_d;

    logic dmem_busy;
    logic load_use;

    logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
    logic ifid_flush_c, idex_flush_c;

    // Data side still waiting on memory, and EX-stage load feeding decode
    assign dmem_busy = (hz.exmem_dren | hz.exmem_dwen) & ~hz.dhit;
    assign load_use  = hz.idex_dren & (hz.idex_rt != REG_W'(0)) &
                       ((hz.idex_rt == hz.ifid_rs) | (hz.idex_rt == hz.ifid_rt));

    // State register; reset returns to RUN from any state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and latch controls by fixed priority
    always_comb begin
        state_d      = state_q;
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        idex_en_c    = 1'b1;
        exmem_en_c   = 1'b1;
        memwb_en_c   = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;

        if (RST) begin
            pc_en_c      = 1'b0;
            ifid_en_c    = 1'b0;
            idex_en_c    = 1'b0;
            exmem_en_c   = 1'b0;
            memwb_en_c   = 1'b0;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            state_d      = RUN;
        end else if (state_q == HALTED) begin
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_en_c  = 1'b0;
            exmem_en_c = 1'b0;
            memwb_en_c = 1'b0;
        end else if (dmem_busy) begin
            // full freeze keeps a pending LOAD_STALL and defers any halt
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_en_c  = 1'b0;
            exmem_en_c = 1'b0;
            memwb_en_c = 1'b0;
        end else begin
            // any unfrozen cycle leaves LOAD_STALL unless a new stall starts
            state_d = RUN;
            if (hz.redirect) begin
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
            end else if (load_use && (state_q == RUN)) begin
                pc_en_c      = 1'b0;
                ifid_en_c    = 1'b0;
                idex_flush_c = 1'b1;
                state_d      = LOAD_STALL;
            end else if (!hz.ihit) begin
                pc_en_c      = 1'b0;
                ifid_flush_c = 1'b1;
            end

            if (hz.memwb_halt) begin
                memwb_en_c = 1'b0;
                state_d    = HALTED;
            end
        end
    end

    assign hz.pc_en      = pc_en_c;
    assign hz.ifid_en    = ifid_en_c;
    assign hz.idex_en    = idex_en_c;
    assign hz.exmem_en   = exmem_en_c;
    assign hz.memwb_en   = memwb_en_c;
    assign hz.ifid_flush = ifid_flush_c;
    assign hz.idex_flush = idex_flush_c;
    assign hz.halted     = (state_q == HALTED) & ~RST;

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counts of stalled-PC and flushed-ID/EX cycles, frozen when halted
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != HALTED) begin
            if (!pc_en_c && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (idex_flush_c && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = CNT_W'(0);
    assign hz.flush_cnt = CNT_W'(0);
`endif

endmodule
